// File: rtl/coin_session_ctrl.sv
// coin_session_ctrl: coin-credit session controller driving a BCD countdown chain (in: Clk nReset CoinIn ModeSel S1 S2 S3; out: CounterEnable CounterInput Active Done Credits Fault)
module coin_session_ctrl #(
  parameter int TICK_DIV    = 1,
  parameter int MAX_CREDIT  = 15,
  parameter int ARM_TIMEOUT = 4
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       CoinIn,
  input  logic       ModeSel,
  input  logic [3:0] S1,
  input  logic [3:0] S2,
  input  logic [3:0] S3,
  output logic       CounterEnable,
  output logic [3:0] CounterInput,
  output logic       Active,
  output logic       Done,
  output logic [3:0] Credits,
  output logic       Fault
);
  typedef enum logic [2:0] {IDLE, ARM, RUN, DONE, FAULT} stateType;
  stateType state, stateNext;
  logic coinMeta, coinSync, coinPrev, coinEvt;
  logic [15:0] preCnt;
  logic [7:0] armTimer, armNext;
  logic [3:0] ciNext, afterDec, creditsNext;
  logic tick, zero, dec, inc;
  assign tick = preCnt == 16'(TICK_DIV - 1);
  assign zero = S1 == 4'd0 && S2 == 4'd0 && S3 == 4'd0;
  assign CounterEnable = tick && (state == ARM || (state == RUN && !zero));
  assign Active = state == ARM || state == RUN;
  assign Done = state == DONE;
  assign Fault = state == FAULT;
  assign afterDec = Credits - {3'd0, dec};
  assign inc = coinEvt && state != IDLE && afterDec != 4'(MAX_CREDIT);
  assign creditsNext = afterDec + {3'd0, inc};
  always_comb begin
    stateNext = state;
    armNext = armTimer;
    ciNext = CounterInput;
    dec = 1'b0;
    case (state)
      IDLE: if (coinEvt) begin
        ciNext = ModeSel ? 4'd1 : 4'd9;
        armNext = 8'd0;
        stateNext = ARM;
      end
      ARM: if (!zero) stateNext = RUN;
      else if (tick) begin
        armNext = armTimer + 8'd1;
        stateNext = armNext == 8'(ARM_TIMEOUT) ? FAULT : ARM;
      end
      RUN: stateNext = zero ? DONE : RUN;
      DONE: if (Credits != 4'd0) begin
        dec = 1'b1;
        ciNext = ModeSel ? 4'd1 : 4'd9;
        armNext = 8'd0;
        stateNext = ARM;
      end else stateNext = IDLE;
      FAULT: stateNext = FAULT;
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) begin
      state <= IDLE;
      Credits <= 4'd0;
      CounterInput <= 4'd9;
      preCnt <= 16'd0;
      armTimer <= 8'd0;
      coinMeta <= 1'b0;
      coinSync <= 1'b0;
      coinPrev <= 1'b0;
      coinEvt <= 1'b0;
    end else begin
      state <= stateNext;
      Credits <= creditsNext;
      CounterInput <= ciNext;
      preCnt <= tick ? 16'd0 : preCnt + 16'd1;
      armTimer <= armNext;
      coinMeta <= CoinIn;
      coinSync <= coinMeta;
      coinPrev <= coinSync;
      coinEvt <= coinSync & ~coinPrev;
    end
endmodule

// File: tb/tb_coin_session_ctrl.sv
// tb_coin_session_ctrl: directed bench for coin_session_ctrl with a behavioural BCD countdown model
module tb_coin_session_ctrl;
  logic clk, nRst, modeSel;
  logic coinA, coinB, coinC;
  logic ceA, ceB, ceC, activeA, activeB, activeC, doneA, doneB, doneC, faultA, faultB, faultC;
  logic [3:0] ciA, ciB, ciC, creditsA, creditsB, creditsC;
  logic [11:0] dA, dB;
  logic [3:0] zeroD;
  int errors, checks;
  typedef struct {
    logic mode;
    int extra;
    logic [3:0] ci;
    logic [3:0] credits;
    int enables;
    int dones;
  } rowType;
  rowType rows[4];
  assign zeroD = 4'd0;
  coin_session_ctrl uA (.Clk(clk), .nReset(nRst), .CoinIn(coinA), .ModeSel(modeSel),
    .S1(dA[3:0]), .S2(dA[7:4]), .S3(dA[11:8]), .CounterEnable(ceA), .CounterInput(ciA),
    .Active(activeA), .Done(doneA), .Credits(creditsA), .Fault(faultA));
  coin_session_ctrl #(.MAX_CREDIT(2)) uB (.Clk(clk), .nReset(nRst), .CoinIn(coinB), .ModeSel(modeSel),
    .S1(dB[3:0]), .S2(dB[7:4]), .S3(dB[11:8]), .CounterEnable(ceB), .CounterInput(ciB),
    .Active(activeB), .Done(doneB), .Credits(creditsB), .Fault(faultB));
  coin_session_ctrl #(.TICK_DIV(4)) uC (.Clk(clk), .nReset(nRst), .CoinIn(coinC), .ModeSel(modeSel),
    .S1(zeroD), .S2(zeroD), .S3(zeroD), .CounterEnable(ceC), .CounterInput(ciC),
    .Active(activeC), .Done(doneC), .Credits(creditsC), .Fault(faultC));
  function automatic logic [11:0] countNext(input logic [11:0] d, input logic [3:0] ci);
    if (d == 12'd0) return {ci, 4'd5, 4'd9};
    if (d[3:0] != 4'd0) return d - 12'd1;
    if (d[7:4] != 4'd0) return {d[11:8], d[7:4] - 4'd1, 4'd9};
    return {d[11:8] - 4'd1, 4'd5, 4'd9};
  endfunction
  always @(posedge clk or negedge nRst)
    if (!nRst) dA <= 12'd0;
    else if (ceA) dA <= countNext(dA, ciA);
  always @(posedge clk or negedge nRst)
    if (!nRst) dB <= 12'd0;
    else if (ceB) dB <= countNext(dB, ciB);
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic doReset();
    nRst = 1'b0;
    coinA = 1'b0;
    coinB = 1'b0;
    coinC = 1'b0;
    step();
    step();
    nRst = 1'b1;
    step();
  endtask
  initial begin
    int n, en, dn, last, ces;
    logic prevDone;
    errors = 0;
    checks = 0;
    modeSel = 1'b0;
    rows[0] = '{mode: 1'b1, extra: 0, ci: 4'd1, credits: 4'd0, enables: 120, dones: 1};
    rows[1] = '{mode: 1'b0, extra: 0, ci: 4'd9, credits: 4'd0, enables: 600, dones: 1};
    rows[2] = '{mode: 1'b0, extra: 3, ci: 4'd9, credits: 4'd3, enables: 2400, dones: 4};
    rows[3] = '{mode: 1'b1, extra: 2, ci: 4'd1, credits: 4'd2, enables: 360, dones: 3};
    nRst = 1'b0;
    coinA = 1'b0;
    coinB = 1'b0;
    coinC = 1'b0;
    #12;
    chk("rst_ce", ceA, 0);
    chk("rst_ci", ciA, 9);
    chk("rst_credits", creditsA, 0);
    chk("rst_active", activeA, 0);
    chk("rst_done", doneA, 0);
    chk("rst_fault", faultA, 0);
    doReset();
    for (int r = 0; r < 4; r++) begin
      doReset();
      modeSel = rows[r].mode;
      coinA = 1'b1;
      n = 0;
      do begin step(); n++; end while (!activeA && n < 10);
      chk("arm_latency", n, 4);
      en = 0;
      dn = 0;
      prevDone = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if (ceA) en++;
        if (prevDone && dn == 1 && rows[r].extra > 0) begin
          chk("rearm_active", activeA, 1);
          chk("rearm_credits", creditsA, rows[r].credits - 4'd1);
        end
        if (doneA) dn++;
        prevDone = doneA;
        if (dn == rows[r].dones && !activeA && !doneA) break;
        coinA = c < 3 || (c >= 20 && c < 20 + 20 * rows[r].extra && (c % 20) < 3);
        if (c == 30 + 20 * rows[r].extra) begin
          chk("queued_credits", creditsA, rows[r].credits);
          chk("latched_ci", ciA, rows[r].ci);
        end
        step();
      end
      chk("enables", en, rows[r].enables);
      chk("dones", dn, rows[r].dones);
      chk("end_credits", creditsA, 0);
      chk("end_active", activeA, 0);
      chk("end_fault", faultA, 0);
    end
    doReset();
    modeSel = 1'b0;
    coinA = 1'b1;
    n = 0;
    do begin step(); n++; end while (!activeA && n < 10);
    for (int c = 0; c < 700 && !doneA; c++) begin
      coinA = c < 3 || (c >= 20 && c < 23);
      if (dA[11:8] != 4'd0) begin
        if (c % 10 == 0) begin
          modeSel = ~modeSel;
          chk("mode_hold_ci", ciA, 9);
        end
      end else modeSel = 1'b1;
      step();
    end
    chk("mode_done_seen", doneA, 1);
    step();
    chk("mode_next_ci", ciA, 1);
    chk("mode_next_active", activeA, 1);
    doReset();
    modeSel = 1'b1;
    coinB = 1'b1;
    n = 0;
    do begin step(); n++; end while (!activeB && n < 10);
    coinB = 1'b0;
    for (int k = 0; k < 18; k++) begin
      coinB = (k % 6) < 3;
      step();
    end
    coinB = 1'b0;
    repeat (4) step();
    chk("sat_credits", creditsB, 2);
    n = 0;
    while (dB != 12'h002 && n < 300) begin step(); n++; end
    chk("sat_reach_002", dB, 12'h002);
    coinB = 1'b1;
    n = 0;
    do begin step(); n++; end while (!doneB && n < 10);
    chk("sat_done_delay", n, 3);
    chk("sat_credits_in_done", creditsB, 2);
    coinB = 1'b0;
    step();
    chk("sat_credits_after_done", creditsB, 2);
    chk("sat_rearm", activeB, 1);
    doReset();
    coinC = 1'b1;
    n = 0;
    do begin step(); n++; end while (!activeC && n < 10);
    chk("pre_arm_latency", n, 4);
    coinC = 1'b0;
    ces = 0;
    last = -1;
    for (int c = 0; c < 40 && !faultC; c++) begin
      if (ceC) begin
        if (last >= 0) chk("pre_spacing", c - last, 4);
        last = c;
        ces++;
      end
      step();
    end
    chk("pre_enables", ces, 4);
    chk("fault_set", faultC, 1);
    chk("fault_active", activeC, 0);
    ces = 0;
    for (int c = 0; c < 30; c++) begin
      if (ceC) ces++;
      coinC = c < 3 || (c >= 10 && c < 13);
      step();
    end
    chk("fault_ce", ces, 0);
    chk("fault_credits", creditsC, 2);
    chk("fault_sticky", faultC, 1);
    doReset();
    modeSel = 1'b1;
    coinA = 1'b1;
    n = 0;
    do begin step(); n++; end while (!activeA && n < 10);
    for (int k = 0; k < 10; k++) begin
      coinA = k < 3 || (k >= 6);
      step();
    end
    coinA = 1'b0;
    n = 0;
    while (dA != 12'h107 && n < 300) begin step(); n++; end
    chk("ar_reach_107", dA, 12'h107);
    chk("ar_pre_credits", creditsA, 1);
    #2 nRst = 1'b0;
    #1;
    chk("ar_active", activeA, 0);
    chk("ar_credits", creditsA, 0);
    chk("ar_ci", ciA, 9);
    chk("ar_ce", ceA, 0);
    chk("ar_done", doneA, 0);
    chk("ar_fault", faultA, 0);
    chk("ar_digits", dA, 0);
    #3 nRst = 1'b1;
    step();
    step();
    coinA = 1'b1;
    n = 0;
    do begin step(); n++; end while (!activeA && n < 10);
    chk("ar_restart_latency", n, 4);
    chk("ar_restart_ci", ciA, 1);
    coinA = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/coin_session_ctrl.md
Name: coin_session_ctrl

Overview:
- Initiator side of the countdown-timer interface. Accepts coin pulses, queues credits and latches the session mode.
- Drives CounterEnable and CounterInput of the countdown counter chain, and reads back its three BCD digits (S1 seconds-ones, S2 seconds-tens, S3 minutes).
- Ends a session when the digits return to 0:00, then starts the next queued credit or returns to idle.

Parameters:
- TICK_DIV, 1: clocks per counter tick. CounterEnable may only be high on tick cycles. Legal range 1..65535.
- MAX_CREDIT, 15: saturation value of the queued-credit counter. Range 1..15.
- ARM_TIMEOUT, 4: number of ticks allowed in ARM for the digits to leave 0:00 before FAULT. Range 1..255.

Ports:
- Clk  input  1  system clock, rising edge.
- nReset  input  1  asynchronous, active-low reset.
- CoinIn  input  1  raw coin-sensor level, asynchronous to Clk.
- ModeSel  input  1  1 = short session (1:59), 0 = long session (9:59). Sampled only at session start.
- S1  input  4  seconds-ones digit from the counter.
- S2  input  4  seconds-tens digit from the counter.
- S3  input  4  minutes digit from the counter.
- CounterEnable  output  1  count strobe to the counter. Combinational from registered state, tick and digits.
- CounterInput  output  4  latched mode to the counter: 4'd1 (short) or 4'd9 (long).
- Active  output  1  high in ARM and RUN.
- Done  output  1  one-cycle pulse when a session ends.
- Credits  output  4  queued credits, not counting the running session.
- Fault  output  1  sticky; high in FAULT.

Behaviour:
- Reset (asynchronous, nReset=0): state=IDLE, Credits=0, CounterInput=4'd9, Done=0, Fault=0, prescaler=0, synchroniser flops=0, arm timer=0. CounterEnable=0 while in reset.
- Coin path:
  - CoinIn passes through a 2-flop synchroniser, then a rising-edge detector. coin_evt is a 1-cycle pulse, valid 3 edges after CoinIn rises.
  - Holding CoinIn high produces exactly one event.
- Prescaler:
  - tick=1 on every cycle when TICK_DIV=1.
  - Otherwise tick=1 once every TICK_DIV cycles. The prescaler free-runs from reset.
- Signal definitions:
  - zero = (S1==0 && S2==0 && S3==0).
  - CounterEnable = tick && (state==ARM || (state==RUN && !zero)).
- IDLE:
  - On coin_evt: latch CounterInput from ModeSel, clear the arm timer, go to ARM.
  - Credits is not incremented by the coin that starts a session.
- ARM:
  - Counter receives its first strobe on the next tick.
  - If !zero: go to RUN.
  - On each tick while zero: increment the arm timer. When the timer reaches ARM_TIMEOUT, go to FAULT.
- RUN:
  - If zero: deassert CounterEnable in the same cycle (no wrap), then go to DONE.
- DONE (exactly 1 cycle, Done=1):
  - If Credits>0: Credits-1, re-latch CounterInput from the current ModeSel, go to ARM.
  - Otherwise go to IDLE.
- FAULT:
  - CounterEnable=0, Active=0, Fault=1. Coins still accumulate in Credits.
  - Exit only via nReset.
- Credits:
  - coin_evt in ARM/RUN/DONE/FAULT increments Credits, saturating at MAX_CREDIT. A coin at saturation is dropped.
  - coin_evt coinciding with the DONE decrement: net change 0 when Credits<MAX_CREDIT. At MAX_CREDIT the result is MAX_CREDIT-1+1 = MAX_CREDIT.
- ModeSel changes during ARM/RUN are ignored. CounterInput stays stable for the whole session.
- Session lengths with a correct counter, measured in enabled ticks: short = 120 (1 in ARM + 119 in RUN), long = 600.
- Reset mid-session returns everything to reset values immediately. The counter shares nReset, so the digits also read 0:00.

Test Plan:
- Short session: TICK_DIV=1, ModeSel=1, single CoinIn pulse → Active rises 4 edges after CoinIn rises, CounterInput=4'd1, digits go 0:00→1:59, CounterEnable high for exactly 120 cycles, Done pulses once, state IDLE, Credits=0.
- Queued credits: 3 coin pulses during a long session (ModeSel=0) → Credits=3. At end, Done pulse followed immediately by ARM with Credits=2. Four sessions total, 2400 enables.
- Saturation and simultaneity: MAX_CREDIT=2, 3 coins mid-session → Credits=2. A coin landing exactly on the DONE cycle leaves Credits at 2 after the decrement.
- Mode latching: toggle ModeSel every 10 cycles during a session → CounterInput constant. Next queued session picks up ModeSel as sampled in DONE.
- Prescale and fault: TICK_DIV=4 with digits held at 0:00 by the bench → CounterEnable pulses once per 4 cycles in ARM. Fault=1 after 4 ticks, Active=0, CounterEnable stays 0. Coins still raise Credits.
- Async reset mid-RUN: assert nReset=0 between edges at digits 1:07 → all outputs at reset values immediately. After release, one coin starts a fresh session.
